// File: rtl/dividend_rebuild.sv
// Rebuilds a dividend as Quotient*Divisor + Remainder with a shift-add engine.
// Optional macro DIVIDEND_REBUILD_EARLY_EXIT_EN stops RUN once the multiplier empties.
module dividend_rebuild #(
    parameter int WIDTH = 8
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic [WIDTH-1:0]   Quotient,
    input  logic [WIDTH-1:0]   Divisor,
    input  logic [WIDTH-1:0]   Remainder,
    output logic               Busy,
    output logic               Done,
    output logic               Error,
    output logic [2*WIDTH-1:0] Dalja
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplr_q, mplr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [2*WIDTH-1:0] dalja_q, dalja_d;
    logic               last;

    // Final iteration detect: fixed count, or multiplier exhausted
`ifdef DIVIDEND_REBUILD_EARLY_EXIT_EN
    assign last = ((mplr_q >> 1) == '0) || (cnt_q == CW'(1));
`else
    assign last = (cnt_q == CW'(1));
`endif

    // State register with synchronous reset
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (Start) state_d = S_LOAD;
            S_LOAD: state_d = err_q ? S_DONE : S_RUN;
            S_RUN:  if (last) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from state
    always_comb begin
        Busy = (state_q == S_LOAD) || (state_q == S_RUN);
        Done = (state_q == S_DONE);
    end

    assign Error = err_q;
    assign Dalja = dalja_q;

    // Datapath next values: operand capture, shift-add step, result latch
    always_comb begin
        acc_d   = acc_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        dalja_d = dalja_q;
        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    acc_d   = {{WIDTH{1'b0}}, Remainder};
                    mcand_d = {{WIDTH{1'b0}}, Divisor};
                    mplr_d  = Quotient;
                    cnt_d   = CW'(WIDTH);
                    err_d   = (Divisor == '0) || (Remainder >= Divisor);
                end
            end
            S_LOAD: begin
                if (err_q) begin
                    dalja_d = '0;
                end
            end
            S_RUN: begin
                acc_d   = acc_q + (mplr_q[0] ? mcand_q : '0);
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                cnt_d   = cnt_q - CW'(1);
                if (last) begin
                    dalja_d = acc_d;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers with synchronous reset
    always_ff @(posedge Clock) begin
        if (Reset) begin
            acc_q   <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            dalja_q <= '0;
        end else begin
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            dalja_q <= dalja_d;
        end
    end

endmodule
